// File: rtl/apple_placer_if.sv
// rtl/apple_placer_if.sv - occupancy query request/acknowledge bundle between placer and snake body
interface apple_placer_if;
  logic       occ_req;
  logic [9:0] occ_x;
  logic [9:0] occ_y;
  logic       occ_ack;
  logic       occ_hit;

  modport master (
    output occ_req,
    output occ_x,
    output occ_y,
    input  occ_ack,
    input  occ_hit
  );

  modport slave (
    input  occ_req,
    input  occ_x,
    input  occ_y,
    output occ_ack,
    output occ_hit
  );
endinterface

// File: rtl/apple_placer.sv
// rtl/apple_placer.sv - LFSR-driven apple relocation with occupancy query and vsync-aligned commit
module apple_placer #(
  parameter int unsigned X_MIN     = 20,
  parameter int unsigned Y_MIN     = 20,
  parameter int unsigned STEP      = 10,
  parameter int unsigned X_CELLS   = 61,
  parameter int unsigned Y_CELLS   = 45,
  parameter int unsigned MAX_TRIES = 15,
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter int unsigned START_X   = 400,
  parameter int unsigned START_Y   = 300
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           apple_eat,
  input  logic           vert_sync,
  apple_placer_if.master occ,
  output logic [9:0]     apple_x,
  output logic [9:0]     apple_y,
  output logic           busy,
  output logic           place_fail
);

  localparam logic [9:0] X_MIN_W   = 10'(X_MIN);
  localparam logic [9:0] Y_MIN_W   = 10'(Y_MIN);
  localparam logic [9:0] STEP_W    = 10'(STEP);
  localparam logic [9:0] X_CELLS_W = 10'(X_CELLS);
  localparam logic [9:0] Y_CELLS_W = 10'(Y_CELLS);
  localparam logic [3:0] TRIES_W   = 4'(MAX_TRIES);
  localparam logic [9:0] START_X_W = 10'(START_X);
  localparam logic [9:0] START_Y_W = 10'(START_Y);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PICK,
    S_QUERY,
    S_CHECK,
    S_FORCE,
    S_COMMIT
  } state_t;

  state_t      state_q;
  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;
  logic [3:0]  try_q;
  logic        vs_q;
  logic [9:0]  apple_x_q;
  logic [9:0]  apple_y_q;
  logic        occ_req_q;
  logic [9:0]  occ_x_q;
  logic [9:0]  occ_y_q;
  logic        busy_q;
  logic        place_fail_q;
  logic [9:0]  new_x_q;
  logic [9:0]  new_y_q;
  logic [9:0]  last_x_q;
  logic [9:0]  last_y_q;
  logic        last_vld_q;

  logic [5:0]  x_idx;
  logic [5:0]  y_idx;
  logic [9:0]  cand_x;
  logic [9:0]  cand_y;
  logic        cand_reject;
  logic        vs_rise;

  assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  assign x_idx  = lfsr_q[5:0];
  assign y_idx  = lfsr_q[11:6];
  assign cand_x = X_MIN_W + {4'd0, x_idx} * STEP_W;
  assign cand_y = Y_MIN_W + {4'd0, y_idx} * STEP_W;

  // Off-grid indices and a repeat of the current spot both burn a try without a query.
  assign cand_reject = ({4'd0, x_idx} >= X_CELLS_W) ||
                       ({4'd0, y_idx} >= Y_CELLS_W) ||
                       ((cand_x == apple_x_q) && (cand_y == apple_y_q));

  assign vs_rise = vert_sync & ~vs_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      lfsr_q       <= SEED;
      try_q        <= 4'd0;
      vs_q         <= 1'b0;
      apple_x_q    <= START_X_W;
      apple_y_q    <= START_Y_W;
      occ_req_q    <= 1'b0;
      occ_x_q      <= 10'd0;
      occ_y_q      <= 10'd0;
      busy_q       <= 1'b0;
      place_fail_q <= 1'b0;
      new_x_q      <= START_X_W;
      new_y_q      <= START_Y_W;
      last_x_q     <= START_X_W;
      last_y_q     <= START_Y_W;
      last_vld_q   <= 1'b0;
    end else begin
      lfsr_q       <= lfsr_d;
      vs_q         <= vert_sync;
      place_fail_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          try_q      <= 4'd0;
          last_vld_q <= 1'b0;
          if (apple_eat) begin
            state_q <= S_PICK;
            busy_q  <= 1'b1;
          end
        end
        S_PICK: begin
          try_q <= try_q + 4'd1;
          if (cand_reject) begin
            state_q <= S_CHECK;
          end else begin
            occ_x_q    <= cand_x;
            occ_y_q    <= cand_y;
            occ_req_q  <= 1'b1;
            last_x_q   <= cand_x;
            last_y_q   <= cand_y;
            last_vld_q <= 1'b1;
            state_q    <= S_QUERY;
          end
        end
        S_QUERY: begin
          if (occ.occ_ack) begin
            occ_req_q <= 1'b0;
            if (occ.occ_hit) begin
              state_q <= S_CHECK;
            end else begin
              new_x_q <= occ_x_q;
              new_y_q <= occ_y_q;
              state_q <= S_COMMIT;
            end
          end
        end
        S_CHECK: begin
          state_q <= (try_q == TRIES_W) ? S_FORCE : S_PICK;
        end
        S_FORCE: begin
          // Fall back to the last queried spot even though it hit the body.
          new_x_q      <= last_vld_q ? last_x_q : START_X_W;
          new_y_q      <= last_vld_q ? last_y_q : START_Y_W;
          place_fail_q <= 1'b1;
          state_q      <= S_COMMIT;
        end
        S_COMMIT: begin
          if (vs_rise) begin
            apple_x_q <= new_x_q;
            apple_y_q <= new_y_q;
            busy_q    <= 1'b0;
            state_q   <= S_IDLE;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          busy_q    <= 1'b0;
          occ_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign occ.occ_req = occ_req_q;
  assign occ.occ_x   = occ_x_q;
  assign occ.occ_y   = occ_y_q;
  assign apple_x     = apple_x_q;
  assign apple_y     = apple_y_q;
  assign busy        = busy_q;
  assign place_fail  = place_fail_q;

endmodule

// File: doc/apple_placer.md
Name: apple_placer

Overview:
- Sequences apple relocation in the snake game.
- On an eat event, it draws pseudo-random grid candidates from an LFSR and rejects any that fall outside the playfield.
- Each in-range candidate is checked against the snake body through a request/acknowledge occupancy query.
- A free candidate is committed as the new apple position during vertical sync so the display never tears mid-frame.
- It replaces the free-running counter scheme and feeds apple_x/apple_y to the apple pixel renderer.

Parameters:
- X_MIN, 20, leftmost legal apple x (pixels)
- Y_MIN, 20, topmost legal apple y (pixels)
- STEP, 10, grid pitch (pixels)
- X_CELLS, 61, number of legal x positions (20..620)
- Y_CELLS, 45, number of legal y positions (20..460)
- MAX_TRIES, 15, candidate attempts before forced placement (1..15)
- SEED, 16'hACE1, LFSR reset value (must be nonzero)
- START_X, 400, apple x after reset
- START_Y, 300, apple y after reset

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- apple_eat  in  1  pulse or level; sampled only in IDLE
- vert_sync  in  1  VGA vertical sync; its rising edge gates commit
- occ_req  out  1  occupancy query valid
- occ_x  out  10  candidate x under query
- occ_y  out  10  candidate y under query
- occ_ack  in  1  query response valid
- occ_hit  in  1  candidate overlaps snake; valid only when occ_ack=1
- apple_x  out  10  current apple x
- apple_y  out  10  current apple y
- busy  out  1  high whenever state is not IDLE
- place_fail  out  1  one-cycle pulse on a forced placement

Behaviour:
- Reset (synchronous, highest priority, legal in any state):
  - state=IDLE, apple_x=START_X, apple_y=START_Y
  - occ_req=0, occ_x=occ_y=0, busy=0, place_fail=0
  - lfsr=SEED, try counter=0, vert_sync history register=0
- LFSR: 16-bit Fibonacci, advances every clock including during busy.
  - lfsr <= {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}
  - Never reaches zero from a nonzero seed.
- Candidate: x_idx=lfsr[5:0], y_idx=lfsr[11:6].
  - cand_x = X_MIN + x_idx*STEP
  - cand_y = Y_MIN + y_idx*STEP
  - Arithmetic is 10-bit unsigned; no overflow for legal indices.
- States:
  - IDLE: if apple_eat=1 -> PICK; clear try counter.
  - PICK: latch candidate from the current lfsr; try counter +1.
    - If x_idx>=X_CELLS, or y_idx>=Y_CELLS, or the candidate equals the current (apple_x, apple_y), the candidate is rejected -> CHECK.
    - Otherwise -> QUERY, driving occ_x/occ_y.
  - QUERY: occ_req=1; occ_x/occ_y held stable until ack.
    - On occ_ack=1: drop occ_req on the next cycle.
    - occ_hit=0 -> COMMIT; occ_hit=1 -> CHECK.
    - occ_ack arriving in the same cycle req first rises is legal.
    - occ_ack while occ_req=0 is ignored.
  - CHECK: if try counter==MAX_TRIES -> FORCE, else -> PICK.
  - FORCE: candidate = last in-range candidate.
    - If no candidate was in range, use (START_X, START_Y).
    - Pulse place_fail for 1 cycle -> COMMIT.
  - COMMIT: wait for a vert_sync rising edge, detected as a 0->1 change vs. the previous-cycle sample.
    - In the edge cycle, load apple_x/apple_y, then -> IDLE.
    - New position is visible the cycle after the edge.
- busy = (state != IDLE), registered.
- apple_eat asserted while busy is ignored, not queued. A level still high on the return to IDLE starts a new placement, so upstream must pulse it.
- Minimum latency (in-range first candidate, immediate ack, vert_sync edge waiting): eat cycle -> PICK -> QUERY -> COMMIT -> update.
- apple_x/apple_y change only in COMMIT or on reset.

Test Plan:
- Reset -> apple_x=400, apple_y=300, busy=0, occ_req=0 on the first cycle after reset release.
- Single-cycle apple_eat; responder acks after 1 cycle with occ_hit=0 -> exactly one query.
  - occ_x in {20,30,...,620}, occ_y in {20,...,460}.
  - apple_x/apple_y equal the queried values only after the next vert_sync rising edge.
  - busy falls in that same cycle.
- Responder always returns occ_hit=1 (MAX_TRIES=15) -> at most 15 tries (rejected + queried).
  - place_fail pulses exactly once.
  - Apple commits to the last queried candidate (or 400,300 if none) on the next vert_sync edge.
- Responder delays occ_ack by 5 cycles -> occ_req stays high and occ_x/occ_y stay constant for all 5 cycles; occ_req=0 the cycle after ack.
- apple_eat re-pulsed during QUERY and COMMIT -> no second placement; one apple update only.
- reset asserted while in QUERY with occ_req=1 -> next cycle occ_req=0, busy=0, apple=(400,300); a late occ_ack afterwards has no effect.
